lfsr_rng_sched: RTL

// - Shares one 4-bit LFSR random source between NREQ requesters over a req/ack handshake.
// - Sequences the LFSR: warm-up after reset, one step per grant, runtime seed load, lock-up recovery.
// - Sits between the LFSR datapath and its consumers; the only block that advances the LFSR.

---
 rtl/lfsr_pkg.sv | 16 +
 rtl/lfsr_step_core.sv | 35 +++
 rtl/lfsr_rng_sched.sv | 134 +++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR random-number scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lfsr_pkg;

    localparam int         LFSR_WIDTH = 4;
    // Feedback mask for x^4+x^3+1: new bit = q[3] ^ q[2]
    localparam logic [3:0] TAPS       = 4'b1100;
    localparam logic [3:0] SEED_DEF   = 4'b0001;

    typedef enum logic {
        WARM  = 1'b0,
        SERVE = 1'b1
    } state_t;

endpackage

// File: rtl/lfsr_step_core.sv
// LFSR state register with load / step / hold control.
// Latency: q updates on the clock edge after load or step is sampled.
// Backpressure: none; load wins over step, neither means hold.
module lfsr_step_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_DEF)
)(
    input  logic             clk,
    input  logic             clr,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] TAP_MASK = WIDTH'(TAPS);

    logic fb;

    assign fb = ^(q & TAP_MASK);

    // LFSR register: async clear to seed, load has priority over a shift
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= SEED;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= {q[WIDTH-2:0], fb};
        end
    end

endmodule

// File: rtl/lfsr_rng_sched.sv
// Shares one LFSR between NREQ requesters: warm-up, round-robin grants, seed load, lock-up recovery.
// Latency: request seen in cycle t -> registered one-hot ack with rnd in cycle t+1.
// Backpressure: at most one grant per cycle; a requester acked this cycle is skipped next cycle.
module lfsr_rng_sched
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = LFSR_WIDTH,
    parameter int               NREQ   = 2,
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(SEED_DEF),
    parameter int               WARMUP = 8
)(
    input  logic             clk,
    input  logic             clr,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  ack,
    output logic [WIDTH-1:0] rnd,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed_in,
    output logic             busy,
    output logic [WIDTH-1:0] q
);

    localparam int              RRW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0]      WARM_N  = 4'(WARMUP);
    localparam logic [RRW-1:0]  RR_INIT = RRW'(NREQ - 1);

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         warm_cnt;
    logic [RRW-1:0]     rr;
    logic               lockup;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic               step;
    logic               warm_done;
    logic               warm_step;
    logic               grant;
    logic [NREQ-1:0]    elig;
    logic               win_vld;
    logic [RRW-1:0]     win_idx;

    // An all-zero state can only come from a fault; reload the seed rather than stick there.
    assign lockup    = (q == '0);
    assign load      = seed_we | lockup;
    assign load_val  = (seed_we && (seed_in != '0)) ? seed_in : SEED;

    assign warm_done = (warm_cnt == WARM_N);
    assign warm_step = (state == WARM) && !load && !warm_done;

    // The requester being acked now is masked so it can drop req without a second grant.
    assign elig      = req & ~ack;
    assign grant     = (state == SERVE) && !load && win_vld;
    assign step      = grant | warm_step;

    // Round-robin search starting one past the last winner
    always_comb begin
        logic [RRW-1:0] cand;
        win_vld = 1'b0;
        win_idx = rr;
        cand    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = RRW'((int'(rr) + i) % NREQ);
            if (!win_vld && elig[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= WARM;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: leave WARM on the last warm-up step (or at once when no warm-up)
    always_comb begin
        state_nxt = state;
        case (state)
            WARM: begin
                if (warm_done || (warm_step && ((warm_cnt + 4'd1) == WARM_N))) begin
                    state_nxt = SERVE;
                end
            end
            SERVE: state_nxt = SERVE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == WARM);
    end

    // Warm-up step counter; stops at WARM_N because warm_step is gated by warm_done
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            warm_cnt <= 4'd0;
        end else if (warm_step) begin
            warm_cnt <= warm_cnt + 4'd1;
        end
    end

    // Grant registers: one-cycle ack pulse, rnd carries the pre-step LFSR value
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ack <= '0;
            rnd <= '0;
            rr  <= RR_INIT;
        end else begin
            ack <= '0;
            if (grant) begin
                ack <= NREQ'(1) << win_idx;
                rnd <= q;
                rr  <= win_idx;
            end
        end
    end

    lfsr_step_core #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .clr      (clr),
        .step     (step),
        .load     (load),
        .load_val (load_val),
        .q        (q)
    );

endmodule
